// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_pkg;

  localparam int unsigned MEM_ADDR_BASE = 1024;
  localparam int unsigned SRAM_DW       = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } mem_req_t;

endpackage

// File: rtl/sram_wait_cnt.sv
// Per-phase wait counter: reloaded on entry to each half-word phase, flags its final cycle.
module sram_wait_cnt #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic load_i,
  output logic last_o
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)                cnt_q <= '0;
    else if (load_i)            cnt_q <= CW'(WAIT_CYCLES - 1);
    else if (cnt_q != '0)       cnt_q <= cnt_q - CW'(1);
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data memory: 32-bit loads/stores as two half-word accesses on a 16-bit SRAM.
module mem_stage_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = MEM_ADDR_BASE,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_rm,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  state_e             state_q;
  mem_req_t           req_q;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        rd_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] dq_o_q;
  logic               oe_q, we_n_q;

  logic               req, last, cnt_load;
  logic [31:0]        off;
  logic [SRAM_AW-2:0] word_d;
  logic               unused_off;

  assign req    = mem_r_en | mem_w_en;
  assign off    = alu_res - ADDR_BASE;
  // Byte offset within the word and bits above the SRAM range are dropped: addresses wrap.
  assign word_d     = off[SRAM_AW:2];
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

  assign cnt_load = ((state_q == S_IDLE) & req) | ((state_q == S_LO) & last);

  sram_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk    (clk),
    .rst_ni (rst),
    .load_i (cnt_load),
    .last_o (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      word_q  <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          state_q    <= S_LO;
          req_q.wr   <= mem_w_en;
          req_q.data <= val_rm;
          word_q     <= word_d;
          addr_q     <= {word_d, 1'b0};
          dq_o_q     <= val_rm[15:0];
          oe_q       <= mem_w_en;
          we_n_q     <= ~mem_w_en;
        end
        // we_n/oe stay asserted across LO->HI; only the address moves.
        S_LO: if (last) begin
          state_q <= S_HI;
          if (!req_q.wr) rd_q[15:0] <= sram_dq_i;
          addr_q  <= {word_q, 1'b1};
          dq_o_q  <= req_q.data[31:16];
        end
        S_HI: if (last) begin
          state_q <= S_DONE;
          if (!req_q.wr) rd_q[31:16] <= sram_dq_i;
          oe_q    <= 1'b0;
          we_n_q  <= 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready      = ((state_q == S_IDLE) & ~req) | (state_q == S_DONE);
  assign read_data  = rd_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = oe_q;
  assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed literal scenarios plus randomized traffic vs a schedule model.
module tb_mem_stage_sram_ctrl;
  localparam int W  = 2;
  localparam int AW = 18;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0]   alu_res = '0, val_rm = '0;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_we_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.ADDR_BASE(1024), .SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .val_rm(val_rm), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  // Asynchronous-read SRAM, written on every clock while we_n is low.
  logic [15:0] sram [0:NW-1] = '{default: 16'h0};
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_o;
  assign sram_dq_i = sram_dq_oe ? 16'h0 : sram[sram_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an access accepted in cycle 0 occupies cycles 1..2W on the bus, DONE at 2W+1.
  logic [15:0] ref_mem [0:NW-1];
  int          k = -1;
  logic [31:0] m_word, m_data, exp_rd, pend_rd;
  logic        m_wr;
  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = 16'h0;
    exp_rd = '0;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return ((a - 32'd1024) >> 2) & ((32'd1 << (AW - 1)) - 1);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      k = -1;
      exp_rd = '0;
    end else if (k < 0) begin
      chk("m_idle_ready", {31'd0, ready}, {31'd0, ~(mem_r_en | mem_w_en)});
      chk("m_idle_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("m_idle_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("m_idle_rdata", read_data, exp_rd);
      if (mem_r_en | mem_w_en) begin
        m_wr   = mem_w_en;
        m_word = word_of(alu_res);
        m_data = val_rm;
        if (m_wr) begin
          ref_mem[2*m_word]   = m_data[15:0];
          ref_mem[2*m_word+1] = m_data[31:16];
        end else
          pend_rd = {ref_mem[2*m_word+1], ref_mem[2*m_word]};
        k = 1;
      end
    end else if (k <= 2*W) begin
      logic hi;
      hi = (k > W);
      chk("m_busy_ready", {31'd0, ready}, 32'd0);
      chk("m_busy_addr", 32'(sram_addr), 2*m_word + 32'(hi));
      chk("m_busy_we_n", {31'd0, sram_we_n}, {31'd0, ~m_wr});
      chk("m_busy_oe", {31'd0, sram_dq_oe}, {31'd0, m_wr});
      if (m_wr) chk("m_busy_dq_o", 32'(sram_dq_o), hi ? 32'(m_data[31:16]) : 32'(m_data[15:0]));
      k++;
    end else begin
      if (!m_wr) exp_rd = pend_rd;
      chk("m_done_ready", {31'd0, ready}, 32'd1);
      chk("m_done_rdata", read_data, exp_rd);
      chk("m_done_we_n", {31'd0, sram_we_n}, 32'd1);
      k = -1;
    end
  end

  task automatic adv();
    @(posedge clk); #1;
  endtask

  // One access of 2W+2 cycles with literal checks; enables are dropped after the request cycle.
  task automatic access(input string nm, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] lo_addr, input logic [31:0] rd_exp);
    mem_r_en = r; mem_w_en = w; alu_res = a; val_rm = d;
    for (int c = 0; c <= 2*W+1; c++) begin
      @(negedge clk);
      chk({nm, "_ready"}, {31'd0, ready}, (c == 2*W+1) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 2*W) begin
        chk({nm, "_addr"}, 32'(sram_addr), lo_addr + ((c > W) ? 32'd1 : 32'd0));
        chk({nm, "_we_n"}, {31'd0, sram_we_n}, {31'd0, ~w});
        if (w) chk({nm, "_dq_o"}, 32'(sram_dq_o), (c > W) ? 32'(d[31:16]) : 32'(d[15:0]));
      end
      if (c == 2*W+1) chk({nm, "_rdata"}, read_data, rd_exp);
      adv();
      if (c == 0) begin mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = $urandom; val_rm = $urandom; end
    end
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    adv(); rst = 1'b1;
    repeat (10) adv();

    access("store", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'd2, 32'd0);
    access("load",  1'b1, 1'b0, 32'd1028, 32'h0,        32'd2, 32'hDEADBEEF);
    access("both",  1'b1, 1'b1, 32'd1024, 32'h12345678, 32'd0, 32'hDEADBEEF);
    access("ld0",   1'b1, 1'b0, 32'd1027, 32'h0,        32'd0, 32'h12345678);

    // Back-to-back store then load at 1032: DONE of the store in cycle 5, load seen in cycle 6.
    mem_w_en = 1'b1; alu_res = 32'd1032; val_rm = 32'hCAFEF00D;
    for (int c = 0; c <= 4*W+3; c++) begin
      @(negedge clk);
      chk("b2b_ready", {31'd0, ready}, (c == 2*W+1 || c == 4*W+3) ? 32'd1 : 32'd0);
      if (c == 4*W+3) chk("b2b_rdata", read_data, 32'hCAFEF00D);
      adv();
      if (c == 2*W+1) begin mem_w_en = 1'b0; mem_r_en = 1'b1; end
      if (c == 2*W+2) mem_r_en = 1'b0;
    end

    // Reset in cycle 3 of a store to word 1000 (never read again).
    mem_w_en = 1'b1; alu_res = 32'd1024 + 32'd4000; val_rm = 32'hA5A55A5A;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) chk("rst_mid_we_n_before", {31'd0, sram_we_n}, 32'd0);
      if (c < 3) adv();
      if (c == 0) mem_w_en = 1'b0;
    end
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_mid_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready}, 32'd1);
    adv(); adv(); rst = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", {31'd0, ready}, 32'd1);
    adv();

    // Random traffic, including requests held or changed while busy and wrapped addresses.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      mem_r_en = ($urandom_range(0, 1) == 1);
      mem_w_en = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) a = 32'd1024 - 32'd4 * $urandom_range(1, 8);
      else                           a = 32'd1024 + 32'd4 * $urandom_range(0, 63);
      alu_res = a | 32'($urandom_range(0, 3));
      val_rm  = $urandom;
      adv();
    end
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    repeat (2*W + 4) adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
